regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter that shares the single register-file write port (regWrite/rd/writeData) between two producers: the ALU write-back path (port 0) and the load write-back path (port 1). Each producer offers a write with a valid/ready handshake; the block picks one winner per cycle by round-robin and registers the winning write into an output stage that drives the register file directly. Writes to x0 are accepted and discarded, so the register file never sees them.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wb0Valid  in  1  ALU port offers a write
- wb0Ready  out  1  ALU write accepted this cycle
- wb0Rd  in  ADDR_W  ALU destination register
- wb0Data  in  DATA_W  ALU write data
- wb1Valid  in  1  load port offers a write
- wb1Ready  out  1  load write accepted this cycle
- wb1Rd  in  ADDR_W  load destination register
- wb1Data  in  DATA_W  load write data
- regWrite  out  1  write enable to the register file (registered)
- rd  out  ADDR_W  destination register to the register file (registered)
- writeData  out  DATA_W  data to the register file (registered)
- conflictCount  out  16  count of contended cycles (see Configuration)

## Operation
- Transfer on port N when wbNValid && wbNReady. wbNReady is combinational from the valids and lastGrant. It is asserted only for the winner and never for both ports in the same cycle.
- Producer rule: once wbNValid is high, it and its rd/data stay stable until the transfer. The arbiter does not need to tolerate withdrawal.
- Arbitration:
  - Only one valid: that port wins.
  - Both valid: the port that did not win the most recent transfer wins.
  - lastGrant updates only on a transfer.
  - Reset value is lastGrant=1, so port 0 wins the first tie.
- Output stage updates every cycle:
  - On a transfer with rd≠0: regWrite<=1, rd<=winner rd, writeData<=winner data.
  - Otherwise: regWrite<=0, and rd/writeData hold their previous values.
- rd=0 transfer: wbNReady is asserted normally and lastGrant updates, but regWrite<=0 (write squashed).
- Same rd on both ports in one cycle: the winner is written first. The loser is accepted on a later cycle, so its data lands last and is the final value.
- No back-pressure from the register file: the output stage is never stalled, so a transfer is possible every cycle.
- Reset:
  - Asynchronous. Clears regWrite, rd, writeData, conflictCount, and sets lastGrant=1.
  - An in-flight output-stage write is dropped and not replayed. The producer treated it as transferred.
  - wbNReady is 0 while reset is high.

## Timing
- Reset values: regWrite=0, rd=0, writeData=0, conflictCount=0, wb0Ready=wb1Ready=0 during reset.
- Latency: transfer in cycle N drives regWrite/rd/writeData during cycle N+1. The register file captures at the rising edge ending cycle N+1.
- Throughput: one write per cycle. Under continuous contention the ports alternate 0,1,0,1…
- Maximum wait for a valid port: 1 cycle.

## Configuration
- WB_STATS_EN defined: conflictCount increments on every cycle where wb0Valid && wb1Valid outside reset. It saturates at 16'hFFFF.
- WB_STATS_EN undefined: no counter flops, and conflictCount is tied to 0.

## Test plan
- Reset then single write: release reset, wb0Valid=1, wb0Rd=5, wb0Data=32'hDEADBEEF in cycle 0. Expect wb0Ready=1 in cycle 0, then regWrite=1, rd=5, writeData=32'hDEADBEEF in cycle 1, then regWrite=0 in cycle 2.
- Tie and round-robin: both ports valid for 4 cycles with distinct rd 1..4. Expect grant order 0,1,0,1 (ports 0 then 1 on the first tie after reset), one regWrite per cycle, and conflictCount=4 when WB_STATS_EN is defined (0 otherwise).
- x0 squash: wb1Valid=1, wb1Rd=0, wb1Data=32'h1234. Expect wb1Ready=1, regWrite stays 0 the next cycle, and lastGrant becomes 1, so a following tie goes to port 0.
- Same-rd collision: both ports valid with rd=7 (port 0 data=1, port 1 data=2) right after reset. Expect writes of 1 then 2 on consecutive cycles; the final register value is 2.
- Reset mid-operation: assert reset asynchronously during the cycle regWrite=1. Expect regWrite, rd, writeData to drop to 0 immediately without waiting for a clock edge, and no write for that transfer after reset releases.
- Saturation (WB_STATS_EN defined): hold both valids for 65 540 cycles. Expect conflictCount to stick at 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing one register-file write port between ALU and load paths.
// Define WB_STATS_EN to build the saturating contention counter; otherwise conflictCount reads 0.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb0Valid,
    output logic              wb0Ready,
    input  logic [ADDR_W-1:0] wb0Rd,
    input  logic [DATA_W-1:0] wb0Data,
    input  logic              wb1Valid,
    output logic              wb1Ready,
    input  logic [ADDR_W-1:0] wb1Rd,
    input  logic [DATA_W-1:0] wb1Data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writeData,
    output logic [15:0]       conflictCount
);

    typedef enum logic {
        GRANT_P0 = 1'b0,
        GRANT_P1 = 1'b1
    } grant_e;

    grant_e            lastGrant_q, lastGrant_d;
    logic              regWrite_q, regWrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;

    logic              grant0, grant1, xfer;
    logic [ADDR_W-1:0] winRd;
    logic [DATA_W-1:0] winData;

    // Ready is held low during reset so no producer sees a transfer that the output stage would drop.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (wb0Valid && wb1Valid) begin
                grant0 = (lastGrant_q == GRANT_P1);
                grant1 = (lastGrant_q == GRANT_P0);
            end else begin
                grant0 = wb0Valid;
                grant1 = wb1Valid;
            end
        end
    end

    assign wb0Ready = grant0;
    assign wb1Ready = grant1;

    always_comb begin
        xfer        = grant0 | grant1;
        winRd       = grant1 ? wb1Rd : wb0Rd;
        winData     = grant1 ? wb1Data : wb0Data;
        lastGrant_d = lastGrant_q;
        if (xfer) begin
            lastGrant_d = grant1 ? GRANT_P1 : GRANT_P0;
        end
        // x0 writes are accepted but squashed here; rd/data keep their last written values.
        regWrite_d  = xfer && (winRd != '0);
        rd_d        = regWrite_d ? winRd : rd_q;
        writeData_d = regWrite_d ? winData : writeData_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant_q <= GRANT_P1;
            regWrite_q  <= 1'b0;
            rd_q        <= '0;
            writeData_q <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            regWrite_q  <= regWrite_d;
            rd_q        <= rd_d;
            writeData_q <= writeData_d;
        end
    end

    assign regWrite  = regWrite_q;
    assign rd        = rd_q;
    assign writeData = writeData_q;

`ifdef WB_STATS_EN
    logic [15:0] conflictCount_q, conflictCount_d;

    always_comb begin
        conflictCount_d = conflictCount_q;
        if (wb0Valid && wb1Valid && (conflictCount_q != 16'hFFFF)) begin
            conflictCount_d = conflictCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflictCount_q <= '0;
        end else begin
            conflictCount_q <= conflictCount_d;
        end
    end

    assign conflictCount = conflictCount_q;
`else
    assign conflictCount = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected write-port outputs are queued per driven cycle
// and compared one cycle later; arbitration expectations are given explicitly per step.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        wb0Valid, wb1Valid;
    logic        wb0Ready, wb1Ready;
    logic [4:0]  wb0Rd, wb1Rd;
    logic [31:0] wb0Data, wb1Data;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic [15:0] conflictCount;

    regfile_wb_arbiter #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb0Valid     (wb0Valid),
        .wb0Ready     (wb0Ready),
        .wb0Rd        (wb0Rd),
        .wb0Data      (wb0Data),
        .wb1Valid     (wb1Valid),
        .wb1Ready     (wb1Ready),
        .wb1Rd        (wb1Rd),
        .wb1Data      (wb1Data),
        .regWrite     (regWrite),
        .rd           (rd),
        .writeData    (writeData),
        .conflictCount(conflictCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks;
    int          errors;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [15:0] exp_cc;
    logic [31:0] last_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs already driven; g: 0 none, 1 port0, 2 port1.
    task automatic tick(input string tag, input int g);
        wr_t exp_o, nxt;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        @(negedge clk);
        check({tag, ".rdy0"}, {31'd0, wb0Ready}, {31'd0, g == 1});
        check({tag, ".rdy1"}, {31'd0, wb1Ready}, {31'd0, g == 2});
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.sb_empty observed=0 expected=1", tag);
        end else begin
            exp_o = sb.pop_front();
            check({tag, ".we"},   {31'd0, regWrite}, {31'd0, exp_o.we});
            check({tag, ".rd"},   {27'd0, rd}, {27'd0, exp_o.rd});
            check({tag, ".data"}, writeData, exp_o.data);
            if (regWrite) last_wr_data = writeData;
        end
        check({tag, ".cc"}, {16'd0, conflictCount}, {16'd0, exp_cc});
`ifdef WB_STATS_EN
        if (wb0Valid && wb1Valid && exp_cc != 16'hFFFF) exp_cc++;
`endif
        wrd  = (g == 2) ? wb1Rd : wb0Rd;
        wdat = (g == 2) ? wb1Data : wb0Data;
        nxt.we = (g != 0) && (wrd != 5'd0);
        if (nxt.we) begin
            m_rd   = wrd;
            m_data = wdat;
        end
        nxt.rd   = m_rd;
        nxt.data = m_data;
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_t seed;
        reset    = 1'b1;
        wb0Valid = 1'b0;
        wb1Valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.we",   {31'd0, regWrite}, 32'd0);
        check("rst.rd",   {27'd0, rd}, 32'd0);
        check("rst.data", writeData, 32'd0);
        check("rst.cc",   {16'd0, conflictCount}, 32'd0);
        reset = 1'b0;
        sb.delete();
        m_rd   = '0;
        m_data = '0;
        exp_cc = '0;
        seed.we   = 1'b0;
        seed.rd   = '0;
        seed.data = '0;
        sb.push_back(seed);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        wb0Valid = v0; wb0Rd = r0; wb0Data = d0;
        wb1Valid = v1; wb1Rd = r1; wb1Data = d1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        last_wr_data = '0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        // Ready must stay low while reset is asserted even with a valid offer.
        wb1Valid = 1'b1;
        #2;
        check("rst.rdy1", {31'd0, wb1Ready}, 32'd0);
        do_reset();

        // Single write from port 0.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick("single.c0", 1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick("single.c1", 0);
        tick("single.c2", 0);

        // Tie round-robin from reset: 0,1,0,1 then port 0 drains.
        do_reset();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        tick("rr.c0", 1);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22);
        tick("rr.c1", 2);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        tick("rr.c2", 1);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44);
        tick("rr.c3", 2);
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        tick("rr.c4", 1);
`ifdef WB_STATS_EN
        check("rr.cc_total", {16'd0, conflictCount}, 32'd4);
`else
        check("rr.cc_total", {16'd0, conflictCount}, 32'd0);
`endif

        // x0 squash on port 1, then the following tie must go to port 0.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        tick("x0.c0", 2);
        drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd10, 32'hB);
        tick("x0.tie", 1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hB);
        tick("x0.p1", 2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick("x0.idle", 0);

        // Same rd on both ports: port 1 data lands last.
        do_reset();
        drive(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        tick("same.c0", 1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2);
        tick("same.c1", 2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick("same.c2", 0);
        tick("same.c3", 0);
        check("same.final", last_wr_data, 32'd2);

        // Asynchronous reset while regWrite is high.
        do_reset();
        drive(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 32'd0);
        tick("mid.c0", 1);
        check("mid.pre_we", {31'd0, regWrite}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h66);
        #2;
        reset = 1'b1;
        #1;
        check("mid.we",   {31'd0, regWrite}, 32'd0);
        check("mid.rd",   {27'd0, rd}, 32'd0);
        check("mid.data", writeData, 32'd0);
        check("mid.rdy1", {31'd0, wb1Ready}, 32'd0);
        do_reset();
        tick("mid.after", 0);
        tick("mid.after2", 0);

        // Long contention: counter saturates (or stays 0 without stats).
        do_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
`ifdef WB_STATS_EN
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat.cc", {16'd0, conflictCount}, 32'h0000FFFF);
`else
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("sat.cc", {16'd0, conflictCount}, 32'd0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
